// File: rtl/enigma_plugboard_pkg.sv
// Shared constants, FSM state type and ASCII helpers for the enigma front end.
package enigma_pkg;

   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_LA = 8'h61;
   localparam int         ALPHABET = 26;
   localparam int         IDX_W    = 208;

   typedef enum logic [2:0] {
      UNCFG,
      CHECK,
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   function automatic logic is_letter(input logic [7:0] ch);
      return ((ch >= ASCII_A)  && (ch <= ASCII_A  + 8'd25)) ||
             ((ch >= ASCII_LA) && (ch <= ASCII_LA + 8'd25));
   endfunction

   function automatic logic [7:0] fold_case(input logic [7:0] ch);
      return ((ch >= ASCII_LA) && (ch <= ASCII_LA + 8'd25)) ? ch - 8'h20 : ch;
   endfunction

   // Alphabet position 0..25 of a letter (either case).
   function automatic logic [4:0] letter_idx(input logic [7:0] ch);
      return 5'(fold_case(ch) - ASCII_A);
   endfunction

endpackage

// File: rtl/enigma_plugboard_if.sv
// Character input handshake plus the issue/done pair towards the rotor core.
interface enigma_plugboard_if;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       core_valid;
   logic [7:0] core_din;
   logic       core_done;

   modport master (output s_valid, s_data, core_done,
                   input  s_ready, core_valid, core_din);
   modport slave  (input  s_valid, s_data, core_done,
                   output s_ready, core_valid, core_din);
endinterface

// File: rtl/enigma_plugboard_fifo.sv
// Small synchronous byte FIFO with flush; DEPTH must be a power of two.
module plug_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_flush,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic [7:0] o_data,
   output logic       o_full,
   output logic       o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W:0]   r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_data  = r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + PTR_W'(1);
         if (w_pop)  r_rd <= r_rd + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/enigma_plugboard.sv
// Plugboard stage: buffers ASCII input, drops non-letters, swaps letters through
// a validated involution table and hands them one at a time to the rotor core.
//
//   state | meaning
//   UNCFG | no valid table loaded, input blocked
//   CHECK | walking the 26 table entries, one per cycle
//   IDLE  | popping the FIFO head (drop or issue)
//   ISSUE | core_valid pulse for the plugged letter
//   WAIT  | waiting for core_done or the timeout
module enigma_plugboard
   import enigma_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               set,
   input  logic [IDX_W-1:0]   plug_idx_in,
   enigma_plugboard_if.slave  bus,
   output logic               busy,
   output logic               cfg_err,
   output logic               timeout_err,
   output logic [CNT_W-1:0]   drop_cnt
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_table [ALPHABET];
   logic [4:0]       r_chk_idx;
   logic             r_chk_fail;
   logic [TMR_W-1:0] r_tmr;
   logic [7:0]       r_core_din;
   logic             r_cfg_err;
   logic             r_tmo_err;
   logic [CNT_W-1:0] r_drop;

   logic       w_full, w_empty, w_push, w_pop;
   logic       w_issue, w_drop, w_chk_end, w_chk_bad, w_tmo;
   logic [7:0] w_head, w_entry, w_back;

   assign bus.s_ready    = (r_state inside {IDLE, ISSUE, WAIT}) && !w_full && !set;
   assign bus.core_valid = (r_state == ISSUE);
   assign bus.core_din   = r_core_din;
   assign busy           = r_state inside {CHECK, ISSUE, WAIT};
   assign cfg_err        = r_cfg_err;
   assign timeout_err    = r_tmo_err;
   assign drop_cnt       = r_drop;
   assign w_push         = bus.s_valid && bus.s_ready;

   // An entry is good when it is an uppercase letter whose own image points back.
   assign w_entry   = r_table[r_chk_idx];
   assign w_back    = r_table[letter_idx(w_entry)];
   assign w_chk_bad = !((w_entry >= ASCII_A) && (w_entry <= ASCII_A + 8'd25)) ||
                      (w_back != ASCII_A + {3'b000, r_chk_idx});

   plug_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (set),
      .i_push  (w_push),
      .i_data  (bus.s_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_issue     = 1'b0;
      w_drop      = 1'b0;
      w_chk_end   = 1'b0;
      w_tmo       = 1'b0;
      if (set) begin
         w_state_nxt = CHECK;
      end else begin
         case (r_state)
            CHECK: begin
               if (r_chk_idx == 5'(ALPHABET - 1)) begin
                  w_chk_end   = 1'b1;
                  w_state_nxt = (r_chk_fail || w_chk_bad) ? UNCFG : IDLE;
               end
            end
            IDLE: begin
               if (!w_empty) begin
                  w_pop = 1'b1;
                  if (is_letter(w_head)) begin
                     w_issue     = 1'b1;
                     w_state_nxt = ISSUE;
                  end else begin
                     w_drop = 1'b1;
                  end
               end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
               if (bus.core_done) begin
                  w_state_nxt = IDLE;
               end else if (r_tmr == '0) begin
                  w_tmo       = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= UNCFG;
         r_chk_idx  <= '0;
         r_chk_fail <= 1'b0;
         r_tmr      <= '0;
         r_core_din <= 8'h00;
         r_cfg_err  <= 1'b0;
         r_tmo_err  <= 1'b0;
         r_drop     <= '0;
         for (int i = 0; i < ALPHABET; i++) r_table[i] <= ASCII_A + 8'(i);
      end else begin
         r_state <= w_state_nxt;
         if (set) begin
            for (int i = 0; i < ALPHABET; i++) r_table[i] <= plug_idx_in[8*i +: 8];
            r_chk_idx  <= '0;
            r_chk_fail <= 1'b0;
         end else if (r_state == CHECK) begin
            r_chk_idx  <= r_chk_idx + 5'd1;
            r_chk_fail <= r_chk_fail | w_chk_bad;
         end
         if (w_chk_end) r_cfg_err <= r_chk_fail | w_chk_bad;
         // Timer counts from the issue edge, so ISSUE is part of the window.
         if (w_issue) begin
            r_core_din <= r_table[letter_idx(w_head)];
            r_tmr      <= TMR_W'(TIMEOUT - 1);
         end else if (r_tmr != '0) begin
            r_tmr <= r_tmr - TMR_W'(1);
         end
         if (w_tmo) r_tmo_err <= 1'b1;
         if (w_drop && (r_drop != '1)) r_drop <= r_drop + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_enigma_plugboard.sv
// Scoreboard bench for enigma_plugboard: accepted characters queue up in a model,
// a monitor pops and checks every core_valid against the plugboard table.
module tb_enigma_plugboard;
   import enigma_pkg::*;

   localparam int FD = 4;
   localparam int TO = 16;
   localparam int CW = 16;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             set = 1'b0;
   logic [IDX_W-1:0] plug_idx_in = '0;
   logic             busy, cfg_err, timeout_err;
   logic [CW-1:0]    drop_cnt;

   enigma_plugboard_if bus();

   enigma_plugboard #(.FIFO_DEPTH(FD), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .set         (set),
      .plug_idx_in (plug_idx_in),
      .bus         (bus),
      .busy        (busy),
      .cfg_err     (cfg_err),
      .timeout_err (timeout_err),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   logic [7:0] m_tbl [26];
   logic [7:0] m_q [$];
   int         m_drops = 0;
   int         checks = 0;
   int         errors = 0;
   int         valid_cnt = 0;
   int         last_valid_cyc = 0;
   int         cyc = 0;
   bit         resp_en = 1'b0;
   bit         resp_rand = 1'b0;
   int         resp_dly = 3;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit m_is_letter(input logic [7:0] c);
      return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
   endfunction

   function automatic logic [7:0] m_map(input logic [7:0] c);
      int k;
      k = (c >= 8'h61) ? int'(c) - 97 : int'(c) - 65;
      return m_tbl[k];
   endfunction

   function automatic bit tbl_ok();
      for (int i = 0; i < 26; i++) begin
         if (m_tbl[i] < 8'h41 || m_tbl[i] > 8'h5A) return 1'b0;
         if (m_tbl[int'(m_tbl[i]) - 65] != 8'(65 + i)) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   task automatic tbl_identity();
      for (int i = 0; i < 26; i++) m_tbl[i] = 8'(65 + i);
   endtask

   task automatic do_set();
      int n;
      bit exp_bad;
      exp_bad = !tbl_ok();
      @(negedge clk);
      bus.s_valid = 1'b0;
      for (int i = 0; i < 26; i++) plug_idx_in[8*i +: 8] = m_tbl[i];
      set = 1'b1;
      m_q.delete();
      @(negedge clk);
      set = 1'b0;
      n = 0;
      for (int k = 0; k < 60; k++) begin
         if (!busy) break;
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", n, 26);
      chk("cfg_err", cfg_err, exp_bad);
      chk("s_ready_after_check", bus.s_ready, !exp_bad);
   endtask

   task automatic push_str(input string s);
      bit acc;
      int tries;
      for (int i = 0; i < s.len(); i++) begin
         acc = 1'b0;
         tries = 0;
         while (!acc && tries < 200) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = s[i];
            #1;
            acc = bus.s_ready;
            tries++;
         end
         if (!acc) fail("push_timeout");
         else m_q.push_back(s[i]);
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
   endtask

   task automatic drain();
      int quiet, n, letters;
      logic [7:0] c;
      quiet = 0; n = 0; letters = 0;
      while (quiet < 8 && n < 3000) begin
         @(negedge clk);
         n++;
         if (busy) quiet = 0;
         else quiet++;
      end
      if (quiet < 8) fail("drain_timeout");
      #1;
      while (m_q.size() > 0) begin
         c = m_q.pop_front();
         if (m_is_letter(c)) letters++;
         else m_drops++;
      end
      chk("missing_issue", letters, 0);
      chk("drop_cnt", drop_cnt, m_drops);
   endtask

   // Monitor: every core_valid consumes the next letter of the model queue.
   initial begin : monitor
      logic [7:0] c;
      forever begin
         @(negedge clk);
         if (bus.core_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            while (m_q.size() > 0 && !m_is_letter(m_q[0])) begin
               void'(m_q.pop_front());
               m_drops++;
            end
            if (m_q.size() == 0) begin
               fail("unexpected_core_valid");
            end else begin
               c = m_q.pop_front();
               chk("core_din", bus.core_din, m_map(c));
            end
         end
      end
   end

   initial begin : responder
      int d;
      bus.core_done = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_en && bus.core_valid === 1'b1) begin
            d = resp_rand ? int'($urandom_range(1, 5)) : resp_dly;
            repeat (d) @(negedge clk);
            bus.core_done = 1'b1;
            @(negedge clk);
            bus.core_done = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int vc, dc, acc_cnt, n, v0, tcyc, perm[26], tmp, j, np, a, b;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_core_valid", bus.core_valid, 0);
      chk("rst_core_din", bus.core_din, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      @(negedge clk);
      reset_n = 1'b1;

      tbl_identity();
      do_set();

      // A<->B swap, latency of the first character.
      resp_en = 1'b1; resp_dly = 3;
      tbl_identity();
      m_tbl[0] = 8'h42; m_tbl[1] = 8'h41;
      do_set();
      vc = valid_cnt;
      push_str("A");
      #1;
      chk("valid_too_early", bus.core_valid, 0);
      @(negedge clk);
      chk("valid_latency", bus.core_valid, 1);
      push_str("b");
      drain();
      chk("valid_count_ab", valid_cnt - vc, 2);

      vc = valid_cnt;
      push_str("3 C");
      drain();
      chk("valid_count_3sC", valid_cnt - vc, 1);

      // Non-involution table.
      tbl_identity();
      m_tbl[0] = 8'h42; m_tbl[1] = 8'h42;
      do_set();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.s_valid = 1'b1; bus.s_data = 8'h41;
         #1;
         chk("s_ready_uncfg", bus.s_ready, 0);
      end
      bus.s_valid = 1'b0;
      chk("busy_uncfg", busy, 0);

      // FIFO fill and timeout with core_done held low.
      tbl_identity();
      m_tbl[2] = 8'h5A; m_tbl[25] = 8'h43;
      do_set();
      resp_en = 1'b0;
      chk("timeout_err_clear", timeout_err, 0);
      vc = valid_cnt;
      acc_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(65 + $urandom_range(0, 25));
         #1;
         if (bus.s_ready) begin
            acc_cnt++;
            m_q.push_back(bus.s_data);
         end else break;
      end
      bus.s_valid = 1'b0;
      chk("accepted_when_full", acc_cnt, 5);
      @(negedge clk);
      #1;
      chk("s_ready_full", bus.s_ready, 0);
      chk("one_issue_before_timeout", valid_cnt - vc, 1);
      v0 = last_valid_cyc;
      n = 0;
      while (timeout_err !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail("timeout_never_set");
      else begin
         tcyc = cyc;
         chk("timeout_latency", tcyc - v0, 16);
         @(negedge clk);
         #1;
         chk("reissue_after_timeout", last_valid_cyc, tcyc + 1);
      end
      drain();

      // set while waiting with three letters buffered.
      vc = valid_cnt;
      push_str("DEFG");
      chk("one_issue_before_set", valid_cnt - vc, 1);
      vc = valid_cnt;
      dc = drop_cnt;
      do_set();
      repeat (20) @(negedge clk);
      chk("no_valid_after_flush", valid_cnt, vc);
      chk("drop_kept", drop_cnt, dc);
      chk("timeout_err_kept", timeout_err, 1);

      // Random involutions with random traffic and core latency.
      resp_en = 1'b1; resp_rand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 26; i++) perm[i] = i;
         for (int i = 25; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
         end
         tbl_identity();
         np = $urandom_range(0, 13);
         for (int p = 0; p < np; p++) begin
            a = perm[2*p]; b = perm[2*p+1];
            m_tbl[a] = 8'(65 + b);
            m_tbl[b] = 8'(65 + a);
         end
         do_set();
         for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) != 0) begin
               case ($urandom_range(0, 7))
                  0, 1, 2, 3: bus.s_data = 8'(65 + $urandom_range(0, 25));
                  4, 5:       bus.s_data = 8'(97 + $urandom_range(0, 25));
                  default:    bus.s_data = 8'($urandom_range(0, 255));
               endcase
               bus.s_valid = 1'b1;
               #1;
               if (bus.s_ready) m_q.push_back(bus.s_data);
            end else begin
               bus.s_valid = 1'b0;
            end
         end
         @(negedge clk);
         bus.s_valid = 1'b0;
         drain();
      end

      // Asynchronous reset while waiting on the core.
      resp_en = 1'b0;
      push_str("Q");
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      m_q.delete();
      chk("arst_core_valid", bus.core_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_s_ready", bus.s_ready, 0);
      chk("arst_drop_cnt", drop_cnt, 0);
      chk("arst_core_din", bus.core_din, 0);
      chk("arst_timeout_err", timeout_err, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
